// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions for the packet CRC generator and receive checker.
package crc_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
  localparam int unsigned FCS_BYTES    = 4;

  typedef enum logic [1:0] {
    PAYLOAD,
    FCS,
    DRAIN,
    RESULT
  } crc_rx_state_t;

  // Reflected CRC-32 advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_update_byte(
    input logic [31:0] crc,
    input logic [7:0]  data,
    input logic [31:0] poly = CRC32_POLY
  );
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_rx_checker.sv
// Receive-side CRC-32 checker: reassembles a byte-serial payload, captures the
// trailing FCS and reports CRC pass/fail plus frame length errors.
module crc_rx_checker
  import crc_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 40,
  parameter logic [31:0] CRC_POLY      = 32'hEDB88320
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*PAYLOAD_BYTES-1:0] out_payload,
  output logic [31:0]                out_crc_calc,
  output logic [31:0]                out_crc_rx,
  output logic                       out_crc_ok,
  output logic                       out_len_err
);

  localparam int unsigned      CNT_W    = $clog2(PAYLOAD_BYTES);
  localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_FCS = CNT_W'(FCS_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  crc_rx_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [3:0][7:0]  rx_q, rx_d;
  logic [31:0]      calc_d;

  // Byte 0 lands at index 0, which is the MS byte of the packed vector.
  logic [0:PAYLOAD_BYTES-1][7:0] pay_q;

  logic        ready_q;
  logic        valid_q;
  logic [31:0] calc_q;
  logic        ok_q;
  logic        len_err_q;

  logic accept;
  logic finish;
  logic len_err_d;
  logic clear;

  assign accept = in_valid && ready_q;
  assign calc_d = crc_d ^ CRC32_XOROUT;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PAYLOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and frame bookkeeping; any in_last before FCS byte 3 is a short frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    rx_d      = rx_q;
    finish    = 1'b0;
    len_err_d = 1'b0;
    clear     = 1'b0;
    case (state_q)
      PAYLOAD: begin
        if (accept) begin
          crc_d = crc32_update_byte(crc_q, in_data, CRC_POLY);
          cnt_d = cnt_q + CNT_ONE;
          if (in_last) begin
            finish    = 1'b1;
            len_err_d = 1'b1;
          end else if (cnt_q == LAST_PAY) begin
            state_d = FCS;
            cnt_d   = '0;
          end
        end
      end
      FCS: begin
        if (accept) begin
          rx_d[cnt_q[1:0]] = in_data;
          cnt_d            = cnt_q + CNT_ONE;
          if (cnt_q == LAST_FCS) begin
            if (in_last) begin
              finish = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else if (in_last) begin
            finish    = 1'b1;
            len_err_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          finish    = 1'b1;
          len_err_d = 1'b1;
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
          crc_d   = CRC32_INIT;
          rx_d    = '0;
          clear   = 1'b1;
        end
      end
      default: begin
        state_d = PAYLOAD;
      end
    endcase
    if (finish) begin
      state_d = RESULT;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      crc_q     <= CRC32_INIT;
      rx_q      <= '0;
      pay_q     <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      calc_q    <= '0;
      ok_q      <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      rx_q    <= rx_d;
      ready_q <= (state_d != RESULT);
      if (clear) begin
        pay_q <= '0;
      end else if (state_q == PAYLOAD && accept) begin
        pay_q[cnt_q] <= in_data;
      end
      if (finish) begin
        valid_q   <= 1'b1;
        calc_q    <= calc_d;
        len_err_q <= len_err_d;
        ok_q      <= (calc_d == rx_d) && !len_err_d;
      end else if (clear) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign in_ready     = ready_q;
  assign out_valid    = valid_q;
  assign out_payload  = pay_q;
  assign out_crc_calc = calc_q;
  assign out_crc_rx   = rx_q;
  assign out_crc_ok   = ok_q;
  assign out_len_err  = len_err_q;

endmodule
